// File: rtl/islip_pkg.sv
// Shared definitions for the iSLIP crossbar scheduler: FSM state encodings
// and the width helpers used to size pointers and counters.
package islip_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GRANT  = 3'd1,
      S_ACCEPT = 3'd2,
      S_ISSUE  = 3'd3,
      S_WAIT   = 3'd4
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int k = 0; k < 32; k++) begin
         r = ((64'd1 << k) < 64'(v)) ? 32'(k + 1) : r;
      end
      return r;
   endfunction

   // Never zero, so a single-entry pointer still gets a legal 1-bit vector.
   function automatic int unsigned ptr_w(input int unsigned n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational programmable-priority round-robin arbiter: grants the first
// requester at or above ptr_i, wrapping to index 0 when none is found.
module rr_arbiter
   import islip_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]          req_i,
   input  logic [ptr_w(N)-1:0]   ptr_i,
   output logic [N-1:0]          gnt_o
);

   localparam int W = ptr_w(N);

   logic [N-1:0] mask_s;
   logic [N-1:0] hi_s;
   logic [N-1:0] sel_s;
   logic         found_s;

   // Thermometer mask of indices at or above the priority pointer
   always_comb begin
      mask_s = '0;
      for (int k = 0; k < N; k++) begin
         mask_s[k] = (W'(k) >= ptr_i);
      end
   end

   assign hi_s  = req_i & mask_s;
   assign sel_s = (|hi_s) ? hi_s : req_i;

   // Lowest set bit of the selected half gives the wrapped round-robin pick
   always_comb begin
      gnt_o   = '0;
      found_s = 1'b0;
      for (int k = 0; k < N; k++) begin
         gnt_o[k] = sel_s[k] & ~found_s;
         found_s  = found_s | sel_s[k];
      end
   end

endmodule

// File: rtl/islip_scheduler.sv
// iSLIP crossbar scheduler: snapshots the VOQ request matrix, runs ITER
// request/grant/accept iterations, then issues one read per matched input.
module islip_scheduler
   import islip_pkg::*;
#(
   parameter int PORT = 8,
   parameter int ITER = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PORT*PORT-1:0] i_req,
   output logic [PORT-1:0]      o_rd,
   output logic [PORT*PORT-1:0] o_rd_port,
   output logic [PORT*PORT-1:0] o_xbar,
   output logic                 o_busy
);

   localparam int PW = ptr_w(PORT);
   localparam int IW = ptr_w(ITER);

   state_t               state_q;
   logic [PORT*PORT-1:0] req_q;
   logic [PORT*PORT-1:0] gnt_q;      // [j*PORT+i]: output j grants input i
   logic [PORT*PORT-1:0] match_q;    // [i*PORT+j]: input i matched to output j
   logic [PORT*PW-1:0]   g_ptr_q;
   logic [PORT*PW-1:0]   a_ptr_q;
   logic [IW-1:0]        iter_q;
   logic [PORT-1:0]      rd_q;
   logic [PORT*PORT-1:0] rd_port_q;
   logic [PORT*PORT-1:0] xbar_q;
   logic                 busy_q;

   logic [PORT*PORT-1:0] greq_s;
   logic [PORT*PORT-1:0] gnt_s;
   logic [PORT*PORT-1:0] areq_s;
   logic [PORT*PORT-1:0] acc_s;
   logic [PORT*PORT-1:0] match_t_s;
   logic [PORT*PORT-1:0] match_d;
   logic [PORT*PORT-1:0] xbar_d;
   logic [PORT-1:0]      rd_d;
   logic [PORT-1:0]      in_m_s;
   logic [PORT-1:0]      out_m_s;
   logic [PORT*PW-1:0]   g_ptr_d;
   logic [PORT*PW-1:0]   a_ptr_d;

   function automatic logic [PW-1:0] ptr_inc(input int v);
      return (v >= PORT - 1) ? '0 : PW'(v + 1);
   endfunction

   for (genvar j = 0; j < PORT; j++) begin : g_port
      for (genvar i = 0; i < PORT; i++) begin : g_pair
         assign greq_s[j*PORT+i]    = req_q[i*PORT+j] & ~in_m_s[i] & ~out_m_s[j];
         assign areq_s[j*PORT+i]    = gnt_q[i*PORT+j] & ~in_m_s[j];
         assign match_t_s[j*PORT+i] = match_q[i*PORT+j];
         assign xbar_d[j*PORT+i]    = match_d[i*PORT+j];
      end
      assign out_m_s[j] = |match_t_s[j*PORT +: PORT];
      assign in_m_s[j]  = |match_q[j*PORT +: PORT];
      assign rd_d[j]    = |match_d[j*PORT +: PORT];

      rr_arbiter #(.N(PORT)) u_grant (
         .req_i (greq_s[j*PORT +: PORT]),
         .ptr_i (g_ptr_q[j*PW +: PW]),
         .gnt_o (gnt_s[j*PORT +: PORT])
      );

      // Instance j here is the accept arbiter of input j
      rr_arbiter #(.N(PORT)) u_accept (
         .req_i (areq_s[j*PORT +: PORT]),
         .ptr_i (a_ptr_q[j*PW +: PW]),
         .gnt_o (acc_s[j*PORT +: PORT])
      );
   end

   assign match_d = match_q | acc_s;

   // Pointer targets one past each accepted partner; unaccepted grants keep theirs
   always_comb begin
      g_ptr_d = g_ptr_q;
      a_ptr_d = a_ptr_q;
      for (int i = 0; i < PORT; i++) begin
         for (int j = 0; j < PORT; j++) begin
            g_ptr_d[j*PW +: PW] = acc_s[i*PORT+j] ? ptr_inc(i) : g_ptr_d[j*PW +: PW];
            a_ptr_d[i*PW +: PW] = acc_s[i*PORT+j] ? ptr_inc(j) : a_ptr_d[i*PW +: PW];
         end
      end
   end

   // Scheduling FSM with snapshot, grant/match state, pointers and outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         req_q     <= '0;
         gnt_q     <= '0;
         match_q   <= '0;
         g_ptr_q   <= '0;
         a_ptr_q   <= '0;
         iter_q    <= '0;
         rd_q      <= '0;
         rd_port_q <= '0;
         xbar_q    <= '0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|i_req) begin
                  req_q   <= i_req;
                  match_q <= '0;
                  gnt_q   <= '0;
                  iter_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_GRANT;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_GRANT: begin
               gnt_q   <= gnt_s;
               state_q <= S_ACCEPT;
            end
            S_ACCEPT: begin
               match_q <= match_d;
               // Only the first iteration moves pointers, which keeps them desynchronised
               if (iter_q == '0) begin
                  g_ptr_q <= g_ptr_d;
                  a_ptr_q <= a_ptr_d;
               end else begin
                  g_ptr_q <= g_ptr_q;
                  a_ptr_q <= a_ptr_q;
               end
               if (iter_q == IW'(ITER - 1)) begin
                  rd_q      <= rd_d;
                  rd_port_q <= match_d;
                  xbar_q    <= xbar_d;
                  state_q   <= S_ISSUE;
               end else begin
                  iter_q  <= iter_q + IW'(1);
                  state_q <= S_GRANT;
               end
            end
            S_ISSUE: begin
               rd_q      <= '0;
               rd_port_q <= '0;
               xbar_q    <= '0;
               state_q   <= S_WAIT;
            end
            S_WAIT: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               rd_q      <= '0;
               rd_port_q <= '0;
               xbar_q    <= '0;
               busy_q    <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign o_rd      = rd_q;
   assign o_rd_port = rd_port_q;
   assign o_xbar    = xbar_q;
   assign o_busy    = busy_q;

endmodule
